// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and the pixel/frame-buffer
// fetch logic. The generator is the master; consumers attach through the slave modport.
interface vga_timing_gen_if #(
    parameter int H_W = 11,
    parameter int V_W = 10
);
    logic           pix_ce;
    logic           h_sync;
    logic           v_sync;
    logic           rgb_en;
    logic           v_blank;
    logic [H_W-1:0] pix_x;
    logic [V_W-1:0] pix_y;
    logic           line_start;
    logic           frame_start;

    modport master (
        input  pix_ce,
        output h_sync, v_sync, rgb_en, v_blank,
        output pix_x, pix_y, line_start, frame_start
    );

    modport slave (
        output pix_ce,
        input  h_sync, v_sync, rgb_en, v_blank,
        input  pix_x, pix_y, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA-style raster timing generator: separate H/V counters with all
// outputs registered and decoded from next-state counts, so they line up with PIX_X/PIX_Y.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC_LEN = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC_LEN = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int H_W        = 11,
    parameter int V_W        = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    vga_timing_gen_if.master    bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC_LEN + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC_LEN + V_BP;

    localparam logic [H_W-1:0] H_LAST     = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_ACT      = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_SYNC_BEG = H_W'(H_ACTIVE + H_FP);
    localparam logic [H_W-1:0] H_SYNC_END = H_W'(H_ACTIVE + H_FP + H_SYNC_LEN);
    localparam logic [V_W-1:0] V_LAST     = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT      = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] V_SYNC_BEG = V_W'(V_ACTIVE + V_FP);
    localparam logic [V_W-1:0] V_SYNC_END = V_W'(V_ACTIVE + V_FP + V_SYNC_LEN);

    logic [H_W-1:0] x_q, x_d;
    logic [V_W-1:0] y_q, y_d;
    logic           h_sync_q, h_sync_d;
    logic           v_sync_q, v_sync_d;
    logic           rgb_en_q, rgb_en_d;
    logic           v_blank_q, v_blank_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;

    // Next-state counters and output decode; with pix_ce low the counts hold so the decode holds too.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (bus.pix_ce) begin
            if (x_q == H_LAST) begin
                x_d = {H_W{1'b0}};
                if (y_q == V_LAST) begin
                    y_d = {V_W{1'b0}};
                end else begin
                    y_d = y_q + V_W'(1);
                end
            end else begin
                x_d = x_q + H_W'(1);
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end

        h_sync_d      = ((x_d >= H_SYNC_BEG) && (x_d < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        v_sync_d      = ((y_d >= V_SYNC_BEG) && (y_d < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        rgb_en_d      = (x_d < H_ACT) && (y_d < V_ACT);
        v_blank_d     = (y_d >= V_ACT);
        line_start_d  = bus.pix_ce && (x_d == {H_W{1'b0}});
        frame_start_d = line_start_d && (y_d == {V_W{1'b0}});
    end

    // State and output registers; reset parks on the last back-porch pixel of the frame.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            x_q           <= H_LAST;
            y_q           <= V_LAST;
            h_sync_q      <= ~H_SYNC_POL;
            v_sync_q      <= ~V_SYNC_POL;
            rgb_en_q      <= 1'b0;
            v_blank_q     <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            h_sync_q      <= h_sync_d;
            v_sync_q      <= v_sync_d;
            rgb_en_q      <= rgb_en_d;
            v_blank_q     <= v_blank_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.pix_x       = x_q;
    assign bus.pix_y       = y_q;
    assign bus.h_sync      = h_sync_q;
    assign bus.v_sync      = v_sync_q;
    assign bus.rgb_en      = rgb_en_q;
    assign bus.v_blank     = v_blank_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
endmodule
